// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Slot layout is fixed to 32-bit PC and instruction fields.
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 32;
    localparam int FETCH_INSTR_W = 32;

    localparam logic [FETCH_INSTR_W-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
        logic                     misalign;
        logic                     filled;
    } fetch_slot_t;

    // Pointer width for a power-of-2 queue depth.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_slot_array.sv
// DEPTH-entry slot register file.
// Each slot has independent alloc (issue), fill (response) and pop (consume) ports.
module fetch_slot_array
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = ptr_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     clear,
    input  logic                     alloc_en,
    input  logic [PW-1:0]            alloc_idx,
    input  logic [FETCH_ADDR_W-1:0]  alloc_pc,
    input  logic                     fill_en,
    input  logic [PW-1:0]            fill_idx,
    input  logic [FETCH_INSTR_W-1:0] fill_instr,
    input  logic                     pop_en,
    input  logic [PW-1:0]            pop_idx,
    input  logic [PW-1:0]            rd_idx,
    output fetch_slot_t              rd_slot
);

    fetch_slot_t slot_q [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                slot_q[g] <= '0;
            end else begin
                if (alloc_en && alloc_idx == PW'(g)) begin
                    slot_q[g].pc       <= alloc_pc;
                    slot_q[g].instr    <= INSTR_NOP;
                    slot_q[g].misalign <= |alloc_pc[1:0];
                    slot_q[g].filled   <= 1'b0;
                end
                if (fill_en && fill_idx == PW'(g)) begin
                    slot_q[g].instr  <= fill_instr;
                    slot_q[g].filled <= 1'b1;
                end
                if (pop_en && pop_idx == PW'(g))
                    slot_q[g].filled <= 1'b0;
                // Redirect wins over any same-cycle fill.
                if (clear)
                    slot_q[g].filled <= 1'b0;
            end
        end
    end

    assign rd_slot = slot_q[rd_idx];

endmodule

// File: rtl/instr_fetch_queue.sv
// In-order instruction fetch queue: issues imem requests for PC-stage addresses,
// pairs returned words with their PCs and presents {pc, instr} to decode.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               pc_valid,
    output logic               pc_ready,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               flush,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic               out_misalign,
    input  logic               out_ready
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = PW + 2;
    localparam logic [DW:0] DROP_MAX = (DW+1)'(2 * DEPTH);

    logic [PW-1:0] wr_ptr, rd_ptr, fill_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] pend;      // allocated slots still waiting for their word
    logic [DW-1:0] drop_cnt;  // responses owed to fetches killed by a redirect

    logic          full;
    logic          alloc, pop, fill, drop, consumed;
    logic [DW:0]   drop_sum;
    fetch_slot_t   head;

    assign full      = (count == CW'(DEPTH));
    assign imem_req  = pc_valid & ~full & ~flush & ~clr;
    assign imem_addr = {pc_in[ADDR_W-1:2], 2'b00};
    assign pc_ready  = imem_req & imem_gnt;
    assign alloc     = pc_ready;

    assign drop      = imem_rvalid & (drop_cnt != '0);
    assign fill      = imem_rvalid & (drop_cnt == '0) & (pend != '0);
    assign consumed  = drop | fill;

    assign out_valid    = head.filled & ~flush;
    assign out_pc       = ADDR_W'(head.pc);
    assign out_instr    = INSTR_W'(head.instr);
    assign out_misalign = head.misalign;
    assign pop          = out_valid & out_ready;

    // Every in-flight fetch at a redirect still returns one word that must be eaten.
    assign drop_sum = {1'b0, drop_cnt} + (DW+1)'(pend) - (DW+1)'(consumed);

    fetch_slot_array #(.DEPTH(DEPTH), .PW(PW)) u_slots (
        .clk        (clk),
        .clr        (clr),
        .clear      (flush),
        .alloc_en   (alloc),
        .alloc_idx  (wr_ptr),
        .alloc_pc   (FETCH_ADDR_W'(pc_in)),
        .fill_en    (fill),
        .fill_idx   (fill_ptr),
        .fill_instr (FETCH_INSTR_W'(imem_rdata)),
        .pop_en     (pop),
        .pop_idx    (rd_ptr),
        .rd_idx     (rd_ptr),
        .rd_slot    (head)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill_ptr <= '0;
            count    <= '0;
            pend     <= '0;
            drop_cnt <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill_ptr <= '0;
            count    <= '0;
            pend     <= '0;
            drop_cnt <= (drop_sum > DROP_MAX) ? DW'(DROP_MAX) : DW'(drop_sum);
        end else begin
            wr_ptr   <= wr_ptr + PW'(alloc);
            rd_ptr   <= rd_ptr + PW'(pop);
            fill_ptr <= fill_ptr + PW'(fill);
            count    <= count + CW'(alloc) - CW'(pop);
            pend     <= pend + CW'(alloc) - CW'(fill);
            drop_cnt <= drop_cnt - DW'(drop);
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue.
module tb_instr_fetch_queue;

    localparam int AW = 32;
    localparam int IW = 32;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          clr;
    logic [AW-1:0] pc_in;
    logic          pc_valid;
    logic          pc_ready;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [IW-1:0] imem_rdata;
    logic          flush;
    logic          out_valid;
    logic [AW-1:0] out_pc;
    logic [IW-1:0] out_instr;
    logic          out_misalign;
    logic          out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_queue #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(D)) dut (
        .clk          (clk),
        .clr          (clr),
        .pc_in        (pc_in),
        .pc_valid     (pc_valid),
        .pc_ready     (pc_ready),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_misalign (out_misalign),
        .out_ready    (out_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        pc_valid    = 1'b0;
        pc_in       = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        flush       = 1'b0;
        out_ready   = 1'b0;
    endtask

    task automatic do_clr;
        idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        idle();
        clr = 1'b1;
        tick();
        tick();
        checks++;
        if ({out_valid, imem_req, pc_ready, out_misalign} !== 4'b0 || out_pc !== '0 || out_instr !== '0) begin
            errors++;
            $display("FAIL reset_init got v=%0b req=%0b rdy=%0b pc=%0h instr=%0h mis=%0b want all 0",
                     out_valid, imem_req, pc_ready, out_pc, out_instr, out_misalign);
        end
        clr = 1'b0;
        tick();
        // load one entry so a mid-run reset has something to clear
        pc_valid = 1'b1; pc_in = 32'h44; imem_gnt = 1'b1;
        tick();
        idle();
        imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_5555;
        tick();
        idle();
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h44 || out_instr !== 32'hAAAA_5555) begin
            errors++;
            $display("FAIL reset_preload got v=%0b pc=%0h instr=%0h want 1 44 aaaa5555",
                     out_valid, out_pc, out_instr);
        end
        pc_valid = 1'b1; pc_in = 32'h48; imem_gnt = 1'b1;
        clr = 1'b1;
        #1;
        checks++;
        if ({out_valid, imem_req, pc_ready, out_misalign} !== 4'b0 || out_pc !== '0 || out_instr !== '0) begin
            errors++;
            $display("FAIL reset_mid got v=%0b req=%0b rdy=%0b pc=%0h instr=%0h mis=%0b want all 0",
                     out_valid, imem_req, pc_ready, out_pc, out_instr, out_misalign);
        end
        tick();
        idle();
        clr = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got out_valid=%0b want 0", out_valid);
        end
        // a stray response with nothing outstanding must be ignored
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        idle();
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_stray_rvalid got out_valid=%0b want 0", out_valid);
        end
    endtask

    task automatic test_stream;
        logic [IW-1:0] words [3];
        words[0] = 32'h1000_0001; words[1] = 32'h2000_0002; words[2] = 32'h3000_0003;
        do_clr();
        out_ready = 1'b1; imem_gnt = 1'b1; pc_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            pc_valid    = (c < 3);
            pc_in       = 32'(4 * c);
            imem_rvalid = (c >= 1 && c <= 3);
            imem_rdata  = (c >= 1 && c <= 3) ? words[c-1] : '0;
            #1;
            if (c < 3) begin
                checks++;
                if (pc_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_accept c=%0d got pc_ready=%0b want 1", c, pc_ready);
                end
            end
            if (c < 2 || c == 5) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_idle c=%0d got out_valid=%0b want 0", c, out_valid);
                end
            end else begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== 32'(4 * (c - 2)) || out_instr !== words[c-2] ||
                    out_misalign !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_out c=%0d got v=%0b pc=%0h instr=%0h mis=%0b want 1 %0h %0h 0",
                             c, out_valid, out_pc, out_instr, out_misalign, 4 * (c - 2), words[c-2]);
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_full;
        do_clr();
        pc_valid = 1'b1; imem_gnt = 1'b1;
        for (int i = 0; i < D; i++) begin
            pc_in = 32'h20 + 32'(4 * i);
            #1;
            checks++;
            if (pc_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_accept i=%0d got pc_ready=%0b want 1", i, pc_ready);
            end
            tick();
        end
        pc_in = 32'h30;
        #1;
        checks++;
        if (pc_ready !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL full_block got rdy=%0b req=%0b want 0 0", pc_ready, imem_req);
        end
        imem_rvalid = 1'b1; imem_rdata = 32'hF0F0_0000;
        tick();
        imem_rvalid = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h20 || pc_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_pop got v=%0b pc=%0h rdy=%0b want 1 20 0", out_valid, out_pc, pc_ready);
        end
        tick();
        out_ready = 1'b0;
        #1;
        checks++;
        if (pc_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_one_more got pc_ready=%0b want 1", pc_ready);
        end
        tick();
        #1;
        checks++;
        if (pc_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_again got pc_ready=%0b want 0", pc_ready);
        end
        idle();
    endtask

    task automatic test_flush;
        do_clr();
        pc_valid = 1'b1; imem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc_in       = 32'h10 + 32'(4 * i);
            imem_rvalid = (i == 1);
            imem_rdata  = 32'h0BAD_0010;
            tick();
        end
        imem_rvalid = 1'b0;
        flush = 1'b1; out_ready = 1'b1; pc_in = 32'h100;
        #1;
        checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0 || pc_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle got v=%0b req=%0b rdy=%0b want 0 0 0", out_valid, imem_req, pc_ready);
        end
        tick();
        flush = 1'b0;
        checks++;
        if (dut.drop_cnt !== 4'd3) begin
            errors++;
            $display("FAIL flush_drop_cnt got %0d want 3", dut.drop_cnt);
        end
        for (int j = 0; j < 3; j++) begin
            pc_valid    = (j == 0);
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hBAD0_0000 + 32'(j);
            #1;
            if (j == 0) begin
                checks++;
                if (pc_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL flush_refetch got pc_ready=%0b want 1", pc_ready);
                end
            end
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_discard j=%0d got out_valid=%0b want 0", j, out_valid);
            end
            tick();
        end
        checks++;
        if (dut.drop_cnt !== 4'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drained got drop=%0d v=%0b want 0 0", dut.drop_cnt, out_valid);
        end
        imem_rdata = 32'h0000_0100;
        tick();
        imem_rvalid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'h0000_0100) begin
            errors++;
            $display("FAIL flush_first_out got v=%0b pc=%0h instr=%0h want 1 100 100",
                     out_valid, out_pc, out_instr);
        end
        idle();
    endtask

    task automatic test_backpressure;
        do_clr();
        pc_valid = 1'b1; pc_in = 32'h200; imem_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (imem_req !== 1'b1 || pc_ready !== 1'b0 || imem_addr !== 32'h200) begin
                errors++;
                $display("FAIL bp_hold i=%0d got req=%0b rdy=%0b addr=%0h want 1 0 200",
                         i, imem_req, pc_ready, imem_addr);
            end
            tick();
        end
        imem_gnt = 1'b1;
        #1;
        checks++;
        if (pc_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_grant got pc_ready=%0b want 1", pc_ready);
        end
        tick();
        idle();
        imem_rvalid = 1'b1; imem_rdata = 32'h0200_0013;
        tick();
        idle();
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_instr !== 32'h0200_0013) begin
            errors++;
            $display("FAIL bp_out got v=%0b pc=%0h instr=%0h want 1 200 2000013", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_misalign;
        do_clr();
        pc_valid = 1'b1; pc_in = 32'h6; imem_gnt = 1'b1;
        #1;
        checks++;
        if (imem_addr !== 32'h4 || pc_ready !== 1'b1) begin
            errors++;
            $display("FAIL mis_addr got addr=%0h rdy=%0b want 4 1", imem_addr, pc_ready);
        end
        tick();
        idle();
        imem_rvalid = 1'b1; imem_rdata = 32'h6666_0006;
        tick();
        idle();
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h6 || out_misalign !== 1'b1 || out_instr !== 32'h6666_0006) begin
            errors++;
            $display("FAIL mis_out got v=%0b pc=%0h mis=%0b instr=%0h want 1 6 1 66660006",
                     out_valid, out_pc, out_misalign, out_instr);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_flush();
        test_backpressure();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
